// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequence detector: state encoding,
// default parameter values and a sizing helper for the pulse counter.
package pulse_seq_pkg;

    // Default parameter values used by the top and the channel.
    localparam int DEF_CH     = 4;
    localparam int DEF_PULSES = 2;
    localparam int DEF_TMO_W  = 8;

    // Per-channel state encoding. Plain 2-bit constants keep the encoding
    // fixed and visible to legacy tooling that does not understand enums.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_HIGH = 2'b01;
    localparam state_t ST_LOW  = 2'b10;
    localparam state_t ST_LAST = 2'b11;

    // Width of a counter that has to hold values 0..pulses inclusive.
    function automatic int cnt_width(input int pulses);
        return (pulses < 1) ? 1 : $clog2(pulses + 1);
    endfunction

endpackage : pulse_seq_pkg

// File: rtl/pulse_seq_ch.sv
// One channel of the pulse sequence detector. It counts high pulses on 'a'.
// After PULSES of them it sits in LAST until 'a' falls, which completes the
// sequence. A per-sequence timer aborts a sequence that runs too long.
module pulse_seq_ch
    import pulse_seq_pkg::*;
#(
    parameter int PULSES = DEF_PULSES,
    parameter int TMO_W  = DEF_TMO_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             a,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic             f,
    output logic             g,
    output logic             err,
    output logic             busy
);

    localparam int CNT_W = cnt_width(PULSES);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PULSES);
    localparam logic [TMO_W-1:0] TMR_SAT = '1;

    // A one-pulse sequence skips HIGH/LOW and goes straight to LAST.
    localparam state_t FIRST_STATE = (PULSES == 1) ? ST_LAST : ST_HIGH;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [TMO_W-1:0] tmr_q;
    logic [TMO_W-1:0] tmr_d;
    logic             done;
    logic             tmo_hit;

    // Completion and timeout conditions seen by the current cycle.
    // NOTE: every signal written in an always_comb gets a value on every path
    // (here directly, later through defaults at the top), so no latches form.
    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        done    = (state_q == ST_LAST) && !a;
        tmo_hit = (state_q != ST_IDLE) && (tmo_limit != '0) && (tmr_q == tmo_limit);
    end

    // Next state and pulse count. The priority is enable, then completion,
    // then timeout, then the normal sequence transitions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en || done || tmo_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (a) begin
                        state_d = FIRST_STATE;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!a) begin
                        state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (a) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == CNT_MAX) ? ST_LAST : ST_HIGH;
                    end
                end
                default: begin
                    // LAST: hold until 'a' falls. That fall is handled as 'done' above.
                    state_d = ST_LAST;
                end
            endcase
        end
    end

    // Sequence timer: zero in IDLE and on the cycle a sequence starts. It
    // counts up while a sequence is active and sticks at all-ones.
    always_comb begin
        tmr_d = '0;
        if ((state_q != ST_IDLE) && (state_d != ST_IDLE)) begin
            tmr_d = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + 1'b1;
        end
    end

    // State, counters and all outputs are registered together, so every
    // output comes straight from a flop.
    // NOTE: sequential state is written only with non-blocking assignments,
    // so every flop samples values from before the clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            f       <= 1'b0;
            g       <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            f       <= (state_d == ST_LAST);
            busy    <= (state_d != ST_IDLE);
            g       <= en && done;
            err     <= en && !done && tmo_hit;
        end
    end

endmodule : pulse_seq_ch

// File: rtl/pulse_seq_fsm.sv
// Multi-channel pulse sequence detector. Each bit of 'a' drives its own
// pulse_seq_ch instance. The channels share only the clock, the reset, the
// enable and the timeout limit.
module pulse_seq_fsm
    import pulse_seq_pkg::*;
#(
    parameter int CH     = DEF_CH,
    parameter int PULSES = DEF_PULSES,
    parameter int TMO_W  = DEF_TMO_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [CH-1:0]    a,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic [CH-1:0]    f,
    output logic [CH-1:0]    g,
    output logic [CH-1:0]    err,
    output logic [CH-1:0]    busy
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        pulse_seq_ch #(
            .PULSES (PULSES),
            .TMO_W  (TMO_W)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .en        (en),
            .a         (a[i]),
            .tmo_limit (tmo_limit),
            .f         (f[i]),
            .g         (g[i]),
            .err       (err[i]),
            .busy      (busy[i])
        );
    end

endmodule : pulse_seq_fsm

// File: doc/pulse_seq_fsm.md
PULSE_SEQ_FSM -- requirements
Module: pulse_seq_fsm

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent channels (1..16).
REQ-002 SHALL have parameter PULSES, default 2, high pulses per completed sequence (1..15).
REQ-003 SHALL have parameter TMO_W, default 8, width of the timeout counter and limit.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1, synchronous enable; low forces all channels to IDLE.
REQ-007 SHALL have port a, input, CH, per-channel level input, synchronous to clock.
REQ-008 SHALL have port tmo_limit, input, TMO_W, timeout in cycles; 0 disables timeout.
REQ-009 SHALL have port f, output, CH, registered; high while a channel is in LAST.
REQ-010 SHALL have port g, output, CH, registered; one-cycle pulse on sequence completion.
REQ-011 SHALL have port err, output, CH, registered; one-cycle pulse on timeout abort.
REQ-012 SHALL have port busy, output, CH, registered; high whenever a channel is not IDLE.

Function
REQ-013 Each channel SHALL run an identical, independent FSM with states IDLE, HIGH, LOW, LAST.
REQ-014 IDLE: a=1 -> pulse count=1; next LAST if PULSES==1, else HIGH; a=0 -> stay.
REQ-015 HIGH: a=0 -> LOW; a=1 -> stay.
REQ-016 LOW: a=1 -> count+1; next LAST if count+1==PULSES, else HIGH; a=0 -> stay.
REQ-017 LAST: a=0 -> IDLE with g=1 for exactly one cycle; a=1 -> stay.
REQ-018 f SHALL be 1 in the cycle after entry to LAST and 0 in the cycle after exit.
REQ-019 g and err SHALL be 0 in every cycle except their single event cycle; never both 1 on one channel.
REQ-020 Pulse count SHALL be ceil(log2(PULSES+1)) bits, clear on IDLE entry, never exceed PULSES.
REQ-021 Timer SHALL clear on IDLE exit, increment by 1 per cycle outside IDLE, saturate at all-ones.
REQ-022 When tmo_limit!=0 and timer==tmo_limit outside IDLE: channel -> IDLE, err=1 one cycle, f=0, no g.
REQ-023 Completion (LAST with a=0) and timeout in the same cycle: completion SHALL win (g=1, err=0).
REQ-024 tmo_limit changed mid-sequence SHALL take effect on the next cycle's compare; no latching.
REQ-025 en=0: next cycle all channels IDLE, f=0, busy=0, count/timer cleared, g=err=0.
REQ-026 en=0 and a completion/timeout in the same cycle: en SHALL win; no g or err emitted.
REQ-027 From IDLE, a held high when a channel returns to IDLE SHALL start a new sequence next cycle.
REQ-028 Channels SHALL share no state; event on channel i SHALL not affect channel j.

Reset
REQ-029 reset low SHALL asynchronously force all channels to IDLE, count=0, timer=0.
REQ-030 reset low SHALL asynchronously force f, g, err, busy to all zero.
REQ-031 Reset mid-sequence SHALL discard progress; no g or err pulse on reset release.
REQ-032 After reset release the first posedge SHALL evaluate IDLE transitions normally.

Structure
REQ-033 Shared package pulse_seq_pkg SHALL hold the state enumeration (2-bit: IDLE=00, HIGH=01, LOW=10, LAST=11) and default parameter constants.
REQ-034 A sub-module pulse_seq_ch SHALL implement one channel; top SHALL instantiate it CH times via generate.
REQ-035 All outputs SHALL be driven directly from flops; no combinational input-to-output path.

Verification
REQ-036 CH=4,PULSES=2,tmo=0: ch0 a=1(3cy),0(2cy),1(3cy),0 -> f0=1 for 3 cycles, g0=1 one cycle, other channels idle.
REQ-037 PULSES=2,tmo_limit=5: ch1 a=1(2cy) then held 0 -> err1=1 once at timer==5, busy1=0 next cycle, g1=0.
REQ-038 tmo_limit=6: ch2 falling edge in LAST exactly when timer==6 -> g2=1, err2=0.
REQ-039 ch3 in LAST, drive reset low mid-cycle -> f,busy,g,err all 0 immediately without clock; no pulse after release.
REQ-040 ch0 in LOW, en=0 one cycle -> busy0=0 next cycle; subsequent pulse starts fresh (count=1, needs 2 pulses for g0).
REQ-041 PULSES=1: single pulse a=1(1cy),0 -> f=1 one cycle, then g=1 one cycle.
